// File: rtl/i2s_master_tx.sv
// I2S bus-master transmitter: derives ws/sdata from the bit clock (falling edge)
// and plays one buffered left/right pair per frame. Define I2S_TX_REPEAT_EN to repeat the last pair on underrun.
module i2s_master_tx #(
  parameter int WIDTH = 16,
  parameter int SLOT  = 32
) (
  input  logic             sclk_in,
  input  logic             rst,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] left_in,
  input  logic [WIDTH-1:0] right_in,
  output logic             ws_out,
  output logic             sdata_out,
  output logic             frame_start,
  output logic             underrun
);

  localparam int FRAME = 2 * SLOT;
  localparam int CW    = $clog2(FRAME);

  generate
    if (SLOT < WIDTH) begin : g_bad_slot
      $error("i2s_master_tx: SLOT must be >= WIDTH");
    end
  endgenerate

  logic [CW-1:0]    cnt;
  logic [CW-1:0]    cnt_nxt;
  logic [CW-1:0]    kidx;
  logic             wrap;
  logic             ws_nxt;
  logic             sd_nxt;
  logic             accept;
  logic             hold_full;
  logic             started;
  logic [WIDTH-1:0] hold_l, hold_r;
  logic [WIDTH-1:0] act_l, act_r;
  logic [WIDTH-1:0] chan;
  logic [WIDTH-1:0] shifted;

  assign s_ready = !hold_full;
  assign accept  = s_valid && !hold_full;

  // NOTE: every signal driven here gets a default first so no latch is inferred.
  always_comb begin
    wrap    = (cnt == CW'(FRAME - 1));
    cnt_nxt = wrap ? '0 : cnt + CW'(1);
    ws_nxt  = (cnt_nxt >= CW'(SLOT));
    kidx    = ws_nxt ? cnt_nxt - CW'(SLOT) : cnt_nxt;
    chan    = ws_nxt ? act_r : act_l;
    shifted = chan << (kidx - CW'(1));
    sd_nxt  = 1'b0;
    if (kidx == '0) begin
      // Slot bit 0 carries the previous channel's LSB only when the slot is fully packed;
      // at c=0 the active register still holds the outgoing frame on this edge.
      if (SLOT == WIDTH) sd_nxt = ws_nxt ? act_l[0] : act_r[0];
    end else if (kidx <= CW'(WIDTH)) begin
      sd_nxt = shifted[WIDTH-1];
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so all reads see pre-edge values.
  always_ff @(negedge sclk_in or negedge rst) begin
    if (!rst) begin
      cnt         <= CW'(FRAME - 1);
      ws_out      <= 1'b1;
      sdata_out   <= 1'b0;
      frame_start <= 1'b0;
      underrun    <= 1'b0;
      hold_full   <= 1'b0;
      started     <= 1'b0;
      hold_l      <= '0;
      hold_r      <= '0;
      act_l       <= '0;
      act_r       <= '0;
    end else begin
      cnt         <= cnt_nxt;
      ws_out      <= ws_nxt;
      sdata_out   <= sd_nxt;
      frame_start <= wrap;
      underrun    <= wrap && !hold_full && started;

      if (accept) begin
        hold_l    <= left_in;
        hold_r    <= right_in;
        hold_full <= 1'b1;
        started   <= 1'b1;
      end

      // Accept needs an empty holding register, so it never collides with the load below.
      if (wrap) begin
        if (hold_full) begin
          act_l     <= hold_l;
          act_r     <= hold_r;
          hold_full <= 1'b0;
        end else begin
`ifdef I2S_TX_REPEAT_EN
          act_l <= act_l;
          act_r <= act_r;
`else
          act_l <= '0;
          act_r <= '0;
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_i2s_master_tx.sv
// Directed bench for i2s_master_tx: a WIDTH=SLOT=16 instance and a WIDTH=16/SLOT=32 instance
// share one bit clock; outputs are sampled on the rising edge, opposite the active falling edge.
module tb_i2s_master_tx;

`ifdef I2S_TX_REPEAT_EN
  localparam bit REPEAT = 1'b1;
`else
  localparam bit REPEAT = 1'b0;
`endif

  logic        sclk = 1'b1;
  logic        rst_a, v_a, rdy_a, ws_a, sd_a, fs_a, ur_a;
  logic [15:0] l_a, r_a;
  logic        rst_b, v_b, rdy_b, ws_b, sd_b, fs_b, ur_b;
  logic [15:0] l_b, r_b;

  int total = 0;
  int bad   = 0;

  always #5 sclk = ~sclk;

  i2s_master_tx #(.WIDTH(16), .SLOT(16)) dut_a (
    .sclk_in(sclk), .rst(rst_a), .s_valid(v_a), .s_ready(rdy_a),
    .left_in(l_a), .right_in(r_a), .ws_out(ws_a), .sdata_out(sd_a),
    .frame_start(fs_a), .underrun(ur_a)
  );

  i2s_master_tx #(.WIDTH(16), .SLOT(32)) dut_b (
    .sclk_in(sclk), .rst(rst_b), .s_valid(v_b), .s_ready(rdy_b),
    .left_in(l_b), .right_in(r_b), .ws_out(ws_b), .sdata_out(sd_b),
    .frame_start(fs_b), .underrun(ur_b)
  );

  // Expected serial bit at counter c for a frame playing (l, r); prev is the outgoing right LSB.
  function automatic logic exp_sd(int w, int s, int c, logic [15:0] l, logic [15:0] r, logic prev);
    int k;
    logic [15:0] ch;
    k  = c % s;
    ch = (c >= s) ? r : l;
    if (k == 0) return (s == w) ? ((c == 0) ? prev : l[0]) : 1'b0;
    if (k <= w) return ch[w-k];
    return 1'b0;
  endfunction

  task automatic test_reset();
    rst_a = 1'b0; rst_b = 1'b0;
    v_a = 1'b0; v_b = 1'b0;
    l_a = '0; r_a = '0; l_b = '0; r_b = '0;
    repeat (3) @(posedge sclk);
    total++; if (ws_a !== 1'b1) begin bad++; $display("FAIL reset_ws_a got=%b exp=1", ws_a); end
    total++; if (sd_a !== 1'b0) begin bad++; $display("FAIL reset_sd_a got=%b exp=0", sd_a); end
    total++; if (rdy_a !== 1'b1) begin bad++; $display("FAIL reset_rdy_a got=%b exp=1", rdy_a); end
    total++; if (fs_a !== 1'b0) begin bad++; $display("FAIL reset_fs_a got=%b exp=0", fs_a); end
    total++; if (ur_a !== 1'b0) begin bad++; $display("FAIL reset_ur_a got=%b exp=0", ur_a); end
    total++; if (ws_b !== 1'b1) begin bad++; $display("FAIL reset_ws_b got=%b exp=1", ws_b); end
    total++; if (rdy_b !== 1'b1) begin bad++; $display("FAIL reset_rdy_b got=%b exp=1", rdy_b); end
  endtask

  // WIDTH=SLOT=16: one pair, zero first frame, pair in second frame, underrun in third.
  task automatic test_packed_slot();
    logic [15:0] el, er;
    v_a = 1'b1; l_a = 16'hA5C3; r_a = 16'h0F0F;
    rst_a = 1'b1;
    @(posedge sclk);
    total++; if (fs_a !== 1'b1) begin bad++; $display("FAIL a_first_fs got=%b exp=1", fs_a); end
    total++; if (ur_a !== 1'b0) begin bad++; $display("FAIL a_first_ur got=%b exp=0", ur_a); end
    total++; if (ws_a !== 1'b0) begin bad++; $display("FAIL a_first_ws got=%b exp=0", ws_a); end
    total++; if (rdy_a !== 1'b0) begin bad++; $display("FAIL a_first_rdy got=%b exp=0", rdy_a); end
    v_a = 1'b0;
    for (int f = 0; f < 3; f++) begin
      for (int c = (f == 0) ? 1 : 0; c < 32; c++) begin
        if (f > 0) @(posedge sclk);
        else if (c > 0) @(posedge sclk);
        el = (f == 1) ? 16'hA5C3 : ((f == 2 && REPEAT) ? 16'hA5C3 : 16'h0000);
        er = (f == 1) ? 16'h0F0F : ((f == 2 && REPEAT) ? 16'h0F0F : 16'h0000);
        total++;
        if (sd_a !== exp_sd(16, 16, c, el, er, (f == 2) ? 1'b1 : 1'b0)) begin
          bad++; $display("FAIL a_sd f=%0d c=%0d got=%b exp=%b", f, c, sd_a,
                          exp_sd(16, 16, c, el, er, (f == 2) ? 1'b1 : 1'b0));
        end
        total++; if (ws_a !== (c >= 16)) begin bad++; $display("FAIL a_ws f=%0d c=%0d got=%b", f, c, ws_a); end
        total++; if (fs_a !== (c == 0)) begin bad++; $display("FAIL a_fs f=%0d c=%0d got=%b", f, c, fs_a); end
        total++;
        if (ur_a !== (f == 2 && c == 0)) begin
          bad++; $display("FAIL a_ur f=%0d c=%0d got=%b exp=%b", f, c, ur_a, (f == 2 && c == 0));
        end
      end
    end
  endtask

  // WIDTH=16/SLOT=32: four pairs offered back to back, then starvation for three frames.
  task automatic test_back_to_back();
    logic [15:0] pl [4];
    logic [15:0] pr [4];
    logic [15:0] el, er;
    int idx, acc, rdy_hi;
    logic pend;
    pl = '{16'h1234, 16'hFFFF, 16'h8000, 16'h5A5A};
    pr = '{16'h8001, 16'h0000, 16'h7FFF, 16'hC3C3};
    idx = 0;
    v_b = 1'b1; l_b = pl[0]; r_b = pr[0];
    rst_b = 1'b1;
    pend = v_b && rdy_b;
    for (int f = 0; f < 7; f++) begin
      acc = 0; rdy_hi = 0;
      for (int c = 0; c < 64; c++) begin
        @(posedge sclk);
        if (pend) begin
          acc++; idx++;
          if (idx < 4) begin l_b = pl[idx]; r_b = pr[idx]; end
          else v_b = 1'b0;
        end
        if (rdy_b === 1'b1) rdy_hi++;
        if (f >= 1 && f <= 4) begin el = pl[f-1]; er = pr[f-1]; end
        else if (f >= 5 && REPEAT) begin el = pl[3]; er = pr[3]; end
        else begin el = '0; er = '0; end
        total++;
        if (sd_b !== exp_sd(16, 32, c, el, er, 1'b0)) begin
          bad++; $display("FAIL b_sd f=%0d c=%0d got=%b exp=%b", f, c, sd_b, exp_sd(16, 32, c, el, er, 1'b0));
        end
        total++; if (ws_b !== (c >= 32)) begin bad++; $display("FAIL b_ws f=%0d c=%0d got=%b", f, c, ws_b); end
        total++; if (fs_b !== (c == 0)) begin bad++; $display("FAIL b_fs f=%0d c=%0d got=%b", f, c, fs_b); end
        total++;
        if (ur_b !== (c == 0 && f >= 5)) begin
          bad++; $display("FAIL b_ur f=%0d c=%0d got=%b exp=%b", f, c, ur_b, (c == 0 && f >= 5));
        end
        pend = v_b && rdy_b;
      end
      total++;
      if (acc !== ((f < 4) ? 1 : 0)) begin
        bad++; $display("FAIL b_accepts f=%0d got=%0d exp=%0d", f, acc, (f < 4) ? 1 : 0);
      end
      if (f < 4) begin
        total++;
        if (rdy_hi !== ((f == 0) ? 0 : 1)) begin
          bad++; $display("FAIL b_ready_cycles f=%0d got=%0d exp=%0d", f, rdy_hi, (f == 0) ? 0 : 1);
        end
      end
    end
  endtask

  task automatic wait_frame_b(input string tag);
    int n;
    n = 0;
    do begin
      @(posedge sclk);
      n++;
    end while (fs_b !== 1'b1 && n < 200);
    total++;
    if (fs_b !== 1'b1) begin bad++; $display("FAIL %s_timeout got=%b exp=1", tag, fs_b); end
  endtask

  // Pair offered on the very edge where the counter wraps with holding empty.
  task automatic test_wrap_accept();
    logic [15:0] el, er;
    wait_frame_b("wrap");
    repeat (63) @(posedge sclk);
    v_b = 1'b1; l_b = 16'hABCD; r_b = 16'h1357;
    @(posedge sclk);
    total++; if (ur_b !== 1'b1) begin bad++; $display("FAIL wrap_ur got=%b exp=1", ur_b); end
    total++; if (fs_b !== 1'b1) begin bad++; $display("FAIL wrap_fs got=%b exp=1", fs_b); end
    total++; if (rdy_b !== 1'b0) begin bad++; $display("FAIL wrap_rdy got=%b exp=0", rdy_b); end
    v_b = 1'b0;
    for (int f = 0; f < 2; f++) begin
      for (int c = (f == 0) ? 1 : 0; c < 64; c++) begin
        @(posedge sclk);
        if (f == 1) begin el = 16'hABCD; er = 16'h1357; end
        else if (REPEAT) begin el = 16'h5A5A; er = 16'hC3C3; end
        else begin el = '0; er = '0; end
        total++;
        if (sd_b !== exp_sd(16, 32, c, el, er, 1'b0)) begin
          bad++; $display("FAIL wrap_sd f=%0d c=%0d got=%b exp=%b", f, c, sd_b, exp_sd(16, 32, c, el, er, 1'b0));
        end
        if (c == 0) begin
          total++; if (ur_b !== 1'b0) begin bad++; $display("FAIL wrap_next_ur got=%b exp=0", ur_b); end
        end
      end
    end
  endtask

  // Reset asserted at c=20 with a pair held; both held and active data must be discarded.
  task automatic test_mid_reset();
    wait_frame_b("mrst");
    v_b = 1'b1; l_b = 16'hFFFF; r_b = 16'hFFFF;
    @(posedge sclk);
    v_b = 1'b0;
    repeat (19) @(posedge sclk);
    total++; if (ws_b !== 1'b0) begin bad++; $display("FAIL mrst_pre_ws got=%b exp=0", ws_b); end
    total++; if (rdy_b !== 1'b0) begin bad++; $display("FAIL mrst_pre_rdy got=%b exp=0", rdy_b); end
    rst_b = 1'b0;
    #1;
    total++; if (ws_b !== 1'b1) begin bad++; $display("FAIL mrst_ws got=%b exp=1", ws_b); end
    total++; if (sd_b !== 1'b0) begin bad++; $display("FAIL mrst_sd got=%b exp=0", sd_b); end
    total++; if (rdy_b !== 1'b1) begin bad++; $display("FAIL mrst_rdy got=%b exp=1", rdy_b); end
    total++; if (fs_b !== 1'b0) begin bad++; $display("FAIL mrst_fs got=%b exp=0", fs_b); end
    total++; if (ur_b !== 1'b0) begin bad++; $display("FAIL mrst_ur got=%b exp=0", ur_b); end
    @(posedge sclk);
    rst_b = 1'b1;
    for (int f = 0; f < 2; f++) begin
      for (int c = 0; c < 64; c++) begin
        @(posedge sclk);
        total++; if (sd_b !== 1'b0) begin bad++; $display("FAIL mrst_sd f=%0d c=%0d got=%b exp=0", f, c, sd_b); end
        total++; if (fs_b !== (c == 0)) begin bad++; $display("FAIL mrst_fs f=%0d c=%0d got=%b", f, c, fs_b); end
        total++; if (ws_b !== (c >= 32)) begin bad++; $display("FAIL mrst_ws f=%0d c=%0d got=%b", f, c, ws_b); end
        total++; if (ur_b !== 1'b0) begin bad++; $display("FAIL mrst_ur f=%0d c=%0d got=%b exp=0", f, c, ur_b); end
        total++; if (rdy_b !== 1'b1) begin bad++; $display("FAIL mrst_rdy f=%0d c=%0d got=%b exp=1", f, c, rdy_b); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_packed_slot();
    test_back_to_back();
    test_wrap_accept();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
